vram_arbiter: RTL and testbench

- Single-port framebuffer (VRAM) access controller for the etch-a-sketch display path.
- Shares one RAM port between three requester classes:
  - display refresh reads, which have absolute priority;
  - a whole-screen clear sweep;
  - two touch-point pixel writers, which share round-robin.
- Sits between the touch-to-pixel logic / ili9341 display streamer and the VRAM block.

---
 rtl/etch_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/vram_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/etch_pkg.sv
// Shared display geometry, VRAM field types and the VRAM arbiter FSM encoding
// for the etch-a-sketch display path.
package etch_pkg;

    localparam int DISPLAY_W = 320;
    localparam int DISPLAY_H = 240;

    typedef logic [16:0] vram_addr_t;
    typedef logic [7:0]  color_t;
    typedef logic [8:0]  pixel_x_t;
    typedef logic [7:0]  pixel_y_t;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } vram_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer moves only when the caller
// reports that the offered grant was actually taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic favor_wr1;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = favor_wr1 ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            favor_wr1 <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            favor_wr1 <= grant[0];
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM access controller: display reads first, then the clear
// sweep, then round-robin touch-point writes.
module vram_arbiter
    import etch_pkg::*;
#(
    parameter int                DISPLAY_W   = etch_pkg::DISPLAY_W,
    parameter int                DISPLAY_H   = etch_pkg::DISPLAY_H,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 17,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr0_req,
    input  logic [8:0]        wr0_x,
    input  logic [7:0]        wr0_y,
    input  logic [DATA_W-1:0] wr0_color,
    output logic              wr0_ack,
    input  logic              wr1_req,
    input  logic [8:0]        wr1_x,
    input  logic [7:0]        wr1_y,
    input  logic [DATA_W-1:0] wr1_color,
    output logic              wr1_ack,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr_ena,
    output logic [DATA_W-1:0] vram_wr_data,
    input  logic [DATA_W-1:0] vram_rd_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DISPLAY_W * DISPLAY_H - 1);

    vram_arb_state_t   state, state_next;
    logic [ADDR_W-1:0] clear_cnt;
    logic              clear_step;
    logic              touch_slot;
    logic [1:0]        touch_grant;
    pixel_x_t          sel_x;
    pixel_y_t          sel_y;
    logic [DATA_W-1:0] sel_color;

    // 320 = 256 + 64, so the default width needs only shifts and adds.
    function automatic logic [ADDR_W-1:0] pixel_addr(input pixel_x_t x, input pixel_y_t y);
        if (DISPLAY_W == 320)
            return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
        else
            return ADDR_W'(y) * ADDR_W'(DISPLAY_W) + ADDR_W'(x);
    endfunction

    function automatic logic in_range(input pixel_x_t x, input pixel_y_t y);
        return (int'(x) < DISPLAY_W) && (int'(y) < DISPLAY_H);
    endfunction

    assign touch_slot = !rst && !rd_req && (state == S_IDLE);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({wr1_req, wr0_req}),
        .advance (touch_slot),
        .grant   (touch_grant)
    );

    assign sel_x     = touch_grant[1] ? wr1_x     : wr0_x;
    assign sel_y     = touch_grant[1] ? wr1_y     : wr0_y;
    assign sel_color = touch_grant[1] ? wr1_color : wr0_color;

    // Grants are held off while reset is asserted so nothing reaches the RAM.
    always_comb begin
        rd_ack       = 1'b0;
        wr0_ack      = 1'b0;
        wr1_ack      = 1'b0;
        vram_addr    = '0;
        vram_wr_ena  = 1'b0;
        vram_wr_data = '0;
        clear_step   = 1'b0;
        if (rst) begin
            rd_ack = 1'b0;
        end else if (rd_req) begin
            rd_ack    = 1'b1;
            vram_addr = rd_addr;
        end else if (state == S_CLEAR) begin
            clear_step   = 1'b1;
            vram_addr    = clear_cnt;
            vram_wr_ena  = 1'b1;
            vram_wr_data = CLEAR_COLOR;
        end else if (touch_grant != 2'b00) begin
            wr0_ack      = touch_grant[0];
            wr1_ack      = touch_grant[1];
            vram_addr    = pixel_addr(sel_x, sel_y);
            vram_wr_ena  = in_range(sel_x, sel_y);
            vram_wr_data = sel_color;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (clear_req) state_next = S_CLEAR;
            S_CLEAR: if (clear_step && (clear_cnt == LAST_ADDR)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: reset abandons a partial sweep; the next clear starts again at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            clear_cnt <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_next;
            rd_valid <= rd_ack;
            if ((state == S_IDLE) && clear_req)
                clear_cnt <= '0;
            else if (clear_step)
                clear_cnt <= clear_cnt + 1'b1;
        end
    end

    assign clear_busy = (state == S_CLEAR);
    assign rd_data    = vram_rd_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter: reset, touch arbitration,
// read priority, clear sweep with stolen cycles, and reset mid-sweep.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [16:0] rd_addr = '0;
    logic        rd_ack, rd_valid;
    logic [7:0]  rd_data;
    logic        wr0_req = 1'b0;
    logic [8:0]  wr0_x = '0;
    logic [7:0]  wr0_y = '0;
    logic [7:0]  wr0_color = '0;
    logic        wr0_ack;
    logic        wr1_req = 1'b0;
    logic [8:0]  wr1_x = '0;
    logic [7:0]  wr1_y = '0;
    logic [7:0]  wr1_color = '0;
    logic        wr1_ack;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic [16:0] vram_addr;
    logic        vram_wr_ena;
    logic [7:0]  vram_wr_data;
    logic [7:0]  vram_rd_data = '0;

    int total = 0;
    int bad   = 0;

    vram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr0_req      (wr0_req),
        .wr0_x        (wr0_x),
        .wr0_y        (wr0_y),
        .wr0_color    (wr0_color),
        .wr0_ack      (wr0_ack),
        .wr1_req      (wr1_req),
        .wr1_x        (wr1_x),
        .wr1_y        (wr1_y),
        .wr1_color    (wr1_color),
        .wr1_ack      (wr1_ack),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .vram_addr    (vram_addr),
        .vram_wr_ena  (vram_wr_ena),
        .vram_wr_data (vram_wr_data),
        .vram_rd_data (vram_rd_data)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, contents are a fixed function of address.
    always @(posedge clk) vram_rd_data <= vram_addr[7:0] ^ 8'hA5;

    function automatic logic [7:0] ram_word(input int a);
        logic [16:0] aa;
        aa = 17'(a);
        return aa[7:0] ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cycles;
    int exp_addr;
    int sweep_bad;

    initial begin
        // ---- reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_busy",  32'(clear_busy), 32'd0);
        check("rst_rdv",   32'(rd_valid), 32'd0);
        check("rst_addr",  32'(vram_addr), 32'd0);
        check("rst_ena",   32'(vram_wr_ena), 32'd0);
        check("rst_wdata", 32'(vram_wr_data), 32'd0);
        check("rst_acks",  32'({rd_ack, wr0_ack, wr1_ack}), 32'd0);

        // ---- both writers held: wr0, wr1, wr0, wr1
        wr0_req = 1'b1; wr0_x = 9'd1; wr0_y = 8'd1; wr0_color = 8'h11;
        wr1_req = 1'b1; wr1_x = 9'd2; wr1_y = 8'd1; wr1_color = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_ack%0d", i), 32'({wr1_ack, wr0_ack}), (i % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr_addr%0d", i), 32'(vram_addr), (i % 2 == 0) ? 32'd321 : 32'd322);
            check($sformatf("rr_data%0d", i), 32'(vram_wr_data), (i % 2 == 0) ? 32'h11 : 32'h22);
            tick();
        end
        wr0_req = 1'b0; wr1_req = 1'b0;

        // ---- single wr0 point (10,2)
        wr0_req = 1'b1; wr0_x = 9'd10; wr0_y = 8'd2; wr0_color = 8'h3F;
        #1;
        check("w0_ack",  32'(wr0_ack), 32'd1);
        check("w0_addr", 32'(vram_addr), 32'd650);
        check("w0_ena",  32'(vram_wr_ena), 32'd1);
        check("w0_data", 32'(vram_wr_data), 32'h3F);
        tick();
        wr0_req = 1'b0;

        // ---- out-of-range x on wr1: acked, not written, pointer still moves
        wr1_req = 1'b1; wr1_x = 9'd320; wr1_y = 8'd0; wr1_color = 8'h5A;
        #1;
        check("oor_x_ack", 32'(wr1_ack), 32'd1);
        check("oor_x_ena", 32'(vram_wr_ena), 32'd0);
        tick();
        wr0_req = 1'b1; wr0_x = 9'd5; wr0_y = 8'd0; wr0_color = 8'h44;
        wr1_x = 9'd0; wr1_y = 8'd240;
        #1;
        check("oor_ptr_ack", 32'({wr1_ack, wr0_ack}), 32'd1);
        tick();
        wr0_req = 1'b0;
        #1;
        check("oor_y_ack", 32'(wr1_ack), 32'd1);
        check("oor_y_ena", 32'(vram_wr_ena), 32'd0);
        tick();
        wr1_x = 9'd319; wr1_y = 8'd239; wr1_color = 8'h55;
        #1;
        check("corner_addr", 32'(vram_addr), 32'd76799);
        check("corner_ena",  32'(vram_wr_ena), 32'd1);
        tick();
        wr1_req = 1'b0;

        // ---- reads beat a pending writer for 3 cycles
        wr0_req = 1'b1; wr0_x = 9'd7; wr0_y = 8'd3; wr0_color = 8'h66;
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_addr = 17'(100 + i);
            #1;
            check($sformatf("rd_ack%0d", i), 32'({rd_ack, wr0_ack}), 32'd2);
            check($sformatf("rd_addr%0d", i), 32'(vram_addr), 32'(100 + i));
            check($sformatf("rd_ena%0d", i), 32'(vram_wr_ena), 32'd0);
            if (i > 0) begin
                check($sformatf("rd_valid%0d", i), 32'(rd_valid), 32'd1);
                check($sformatf("rd_data%0d", i), 32'(rd_data), 32'(ram_word(99 + i)));
            end
            tick();
        end
        rd_req = 1'b0;
        #1;
        check("rd_valid_last", 32'(rd_valid), 32'd1);
        check("rd_data_last",  32'(rd_data), 32'(ram_word(102)));
        check("rd_then_w0",    32'(wr0_ack), 32'd1);
        check("rd_then_addr",  32'(vram_addr), 32'd967);
        tick();
        wr0_req = 1'b0;
        #1;
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
        tick();

        // ---- sweep to address 1000, steal one cycle, then async reset
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        #1;
        check("cl1_busy",  32'(clear_busy), 32'd1);
        check("cl1_addr0", 32'(vram_addr), 32'd0);
        repeat (1000) tick();
        check("cl1_addr1000", 32'(vram_addr), 32'd1000);
        wr0_req = 1'b1; wr0_x = 9'd1; wr0_y = 8'd1;
        rd_req = 1'b1; rd_addr = 17'd5;
        #1;
        check("cl1_rd_ack", 32'({rd_ack, wr0_ack}), 32'd2);
        tick();
        rd_req = 1'b0;
        #1;
        check("cl1_stall",    32'(vram_addr), 32'd1000);
        check("cl1_rd_valid", 32'(rd_valid), 32'd1);
        check("cl1_rd_data",  32'(rd_data), 32'(ram_word(5)));
        check("cl1_no_w0",    32'(wr0_ack), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_ena",   32'(vram_wr_ena), 32'd0);
        check("arst_acks",  32'({rd_ack, wr0_ack, wr1_ack}), 32'd0);
        check("arst_busy",  32'(clear_busy), 32'd0);
        check("arst_rdv",   32'(rd_valid), 32'd0);
        wr0_req = 1'b0;
        @(negedge clk) rst = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        #1;
        check("cl2_busy",  32'(clear_busy), 32'd1);
        check("cl2_addr0", 32'(vram_addr), 32'd0);
        tick();
        check("cl2_addr1", 32'(vram_addr), 32'd1);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("cl2_abort", 32'(clear_busy), 32'd0);
        tick();

        // ---- full sweep with 10 stolen read cycles and a held writer
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wr0_req = 1'b1; wr0_x = 9'd4; wr0_y = 8'd4; wr0_color = 8'h77;
        busy_cycles = 0;
        exp_addr    = 0;
        sweep_bad   = 0;
        while (clear_busy && busy_cycles < 80000) begin
            rd_req    = (busy_cycles >= 500) && (busy_cycles < 510);
            rd_addr   = 17'(busy_cycles);
            clear_req = (busy_cycles == 40000);
            #1;
            busy_cycles++;
            if (rd_req) begin
                if (rd_ack !== 1'b1 || vram_wr_ena !== 1'b0 || wr0_ack !== 1'b0)
                    sweep_bad++;
            end else begin
                if (vram_wr_ena !== 1'b1 || vram_addr !== 17'(exp_addr) ||
                    vram_wr_data !== 8'h00 || wr0_ack !== 1'b0)
                    sweep_bad++;
                exp_addr++;
            end
            tick();
        end
        rd_req = 1'b0; clear_req = 1'b0;
        #1;
        check("sw_busy_cycles", 32'(busy_cycles), 32'd76810);
        check("sw_writes",      32'(exp_addr), 32'd76800);
        check("sw_bad_writes",  32'(sweep_bad), 32'd0);
        check("sw_busy_low",    32'(clear_busy), 32'd0);
        check("sw_w0_ack",      32'(wr0_ack), 32'd1);
        check("sw_w0_addr",     32'(vram_addr), 32'd1284);
        tick();
        wr0_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
